sr_trig_bank: RTL

//   Bank of WIDTH independent clocked set/reset flip-flops: edge-triggered, parametrised

---
 rtl/sr_trig_bank.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/sr_trig_bank.sv
// -----------------------------------------------------------------------------
// sr_trig_bank
//
// Bank of WIDTH independent clocked set/reset flip-flops. Each channel is the
// edge-triggered successor of a gated SR latch. The following are added:
//   - a selectable policy for the S=R=1 case (MODE),
//   - optional synchroniser stages on S/R for signals from other clock domains,
//   - registered edge pulses (Rise/Fall),
//   - a per-channel conflict flag.
// Typical use: sticky status flags, mode bits and IRQ-pending latches.
//
// Parameters
//   WIDTH        number of channels, 1..32
//   MODE         S=R=1 policy: 0 reset-dominant, 1 set-dominant,
//                2 toggle (JK), 3 hold
//   SYNC_STAGES  flop stages on S/R before the core
//                (0 = use S/R directly, 2..3 = CDC synchroniser)
//   INIT_VAL     value loaded into Q on reset and on Clr
//
// Optional feature
//   SR_CONFLICT_CNT_EN  when defined, adds the 8-bit ConflictCnt output and its
//                       saturating counter. When undefined, the port and its
//                       logic are absent.
//
// Ports
//   Clk          in   1      system clock, rising edge
//   Rst_n        in   1      asynchronous active-low reset
//   En           in   1      S/R are acted on only in cycles with En=1
//   Clr          in   1      synchronous clear of Q to INIT_VAL, independent of En
//   S            in   WIDTH  per-channel set request, level-sampled
//   R            in   WIDTH  per-channel reset request, level-sampled
//   Q            out  WIDTH  channel state
//   Qn           out  WIDTH  complement of Q, held in its own register
//   Rise         out  WIDTH  1-cycle pulse when a channel's Q goes 0 -> 1
//   Fall         out  WIDTH  1-cycle pulse when a channel's Q goes 1 -> 0
//   Conflict     out  WIDTH  1-cycle pulse: the channel saw S=R=1 with En=1
//                            in the previous cycle
//   ConflictCnt  out  8      saturating count of conflict cycles
//                            (SR_CONFLICT_CNT_EN only)
// -----------------------------------------------------------------------------
module sr_trig_bank #(
  parameter int               WIDTH       = 8,
  parameter int               MODE        = 0,
  parameter int               SYNC_STAGES = 0,
  parameter logic [WIDTH-1:0] INIT_VAL    = '0
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             En,
  input  logic             Clr,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] R,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn,
  output logic [WIDTH-1:0] Rise,
  output logic [WIDTH-1:0] Fall,
  output logic [WIDTH-1:0] Conflict
`ifdef SR_CONFLICT_CNT_EN
  ,
  output logic [7:0]       ConflictCnt
`endif
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (MODE < 0 || MODE > 3) begin : g_bad_mode
    $error("sr_trig_bank: illegal MODE %0d (legal range 0..3)", MODE);
  end

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("sr_trig_bank: illegal WIDTH %0d (legal range 1..32)", WIDTH);
  end

  if (SYNC_STAGES < 0 || SYNC_STAGES > 3) begin : g_bad_sync
    $error("sr_trig_bank: illegal SYNC_STAGES %0d (legal range 0..3)", SYNC_STAGES);
  end

  // ---------------------------------------------------------------------------
  // Input synchroniser
  // ss/rs are S/R delayed by SYNC_STAGES flops. The stages are cleared only by
  // Rst_n. Clr does not flush them: a request already in flight when Clr is
  // applied still reaches the core afterwards.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] ss;
  logic [WIDTH-1:0] rs;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign ss = S;
    assign rs = R;
  end else begin : g_sync
    logic [WIDTH-1:0] s_pipe [SYNC_STAGES];
    logic [WIDTH-1:0] r_pipe [SYNC_STAGES];

    always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
        for (int i = 0; i < SYNC_STAGES; i++) begin
          s_pipe[i] <= '0;
          r_pipe[i] <= '0;
        end
      end else begin
        s_pipe[0] <= S;
        r_pipe[0] <= R;
        for (int i = 1; i < SYNC_STAGES; i++) begin
          s_pipe[i] <= s_pipe[i-1];
          r_pipe[i] <= r_pipe[i-1];
        end
      end
    end

    assign ss = s_pipe[SYNC_STAGES-1];
    assign rs = r_pipe[SYNC_STAGES-1];
  end

  // ---------------------------------------------------------------------------
  // Next-state decode
  // Priority: Clr, then En=0 (hold), then the per-channel S/R decode.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] conflict_next;

  always_comb begin
    q_next = Q;
    if (Clr) begin
      // Any S/R request sampled in this cycle is dropped.
      q_next = INIT_VAL;
    end else if (En) begin
      for (int i = 0; i < WIDTH; i++) begin
        case ({ss[i], rs[i]})
          2'b10:   q_next[i] = 1'b1;
          2'b01:   q_next[i] = 1'b0;
          2'b11: begin
            case (MODE)
              0:       q_next[i] = 1'b0;
              1:       q_next[i] = 1'b1;
              2:       q_next[i] = ~Q[i];
              default: q_next[i] = Q[i];
            endcase
          end
          default: q_next[i] = Q[i];
        endcase
      end
    end
  end

  // The conflict flag reports the S=R=1 event in every MODE, including hold.
  // It is masked by Clr because Clr discards the request.
  always_comb begin
    conflict_next = ss & rs & {WIDTH{En & ~Clr}};
  end

  // ---------------------------------------------------------------------------
  // State and pulse registers
  // Qn has its own flop so that it is a clean registered output, never a
  // combinational inverter on Q. Rise/Fall are computed from the same Q and
  // q_next, so they are valid in the same cycle as the new Q.
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Q        <= INIT_VAL;
      Qn       <= ~INIT_VAL;
      Rise     <= '0;
      Fall     <= '0;
      Conflict <= '0;
    end else begin
      Q        <= q_next;
      Qn       <= ~q_next;
      Rise     <= ~Q & q_next;
      Fall     <= Q & ~q_next;
      Conflict <= conflict_next;
    end
  end

`ifdef SR_CONFLICT_CNT_EN
  // ---------------------------------------------------------------------------
  // Conflict counter
  // Adds at most one per cycle, however many channels conflict in that cycle.
  // Sticks at 8'hFF. Cleared by Rst_n and by Clr.
  // ---------------------------------------------------------------------------
  logic [7:0] conflict_cnt;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      conflict_cnt <= 8'h00;
    end else if (Clr) begin
      conflict_cnt <= 8'h00;
    end else if ((|conflict_next) && (conflict_cnt != 8'hFF)) begin
      conflict_cnt <= conflict_cnt + 8'h01;
    end
  end

  assign ConflictCnt = conflict_cnt;
`endif

endmodule
